// File: rtl/id_exe_reg_pkg.sv
// Shared instruction encodings (ALU commands, shift types) and field widths
// for the ID/EXE pipeline register.
package id_exe_reg_pkg;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  localparam int EXE_CMD_W  = $bits(exe_cmd_e);
  localparam int DATA_W     = 32;
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;
  localparam int REG_IDX_W  = 4;
  localparam int SR_W       = 4;
  localparam int CNT_W      = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_exe_reg_pipe_reg.sv
// Generic pipeline field register: clr loads zero and wins over en; en loads d.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush-to-bubble and a bubble counter.
// Macro FORWARDING_EN registers source indices for the forwarding unit.
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic                  id_imm,
  input  logic [SHIFT_OP_W-1:0] id_shift_operand,
  input  logic [IMM24_W-1:0]    id_signed_imm_24,
  input  logic [REG_IDX_W-1:0]  id_dest,
  input  logic [SR_W-1:0]       id_sr,
  input  logic [REG_IDX_W-1:0]  id_src1,
  input  logic [REG_IDX_W-1:0]  id_src2,
  output logic                  exe_valid,
  output logic                  exe_wb_en,
  output logic                  exe_mem_r_en,
  output logic                  exe_mem_w_en,
  output logic                  exe_b,
  output logic                  exe_s,
  output logic [EXE_CMD_W-1:0]  exe_exe_cmd,
  output logic [DATA_W-1:0]     exe_pc,
  output logic [DATA_W-1:0]     exe_val_rn,
  output logic [DATA_W-1:0]     exe_val_rm,
  output logic                  exe_imm,
  output logic [SHIFT_OP_W-1:0] exe_shift_operand,
  output logic [IMM24_W-1:0]    exe_signed_imm_24,
  output logic [REG_IDX_W-1:0]  exe_dest,
  output logic [SR_W-1:0]       exe_sr,
  output logic [REG_IDX_W-1:0]  exe_src1,
  output logic [REG_IDX_W-1:0]  exe_src2,
  output logic                  exe_is_mem_command,
  output logic [CNT_W-1:0]      bubble_count
);

  // Stall/flush semantics: freeze=1 holds every field; flush=1 loads a bubble
  // (all zero) and wins over freeze; otherwise the decode entry is captured.
  logic cap_en;
  logic bubble;
  logic wb_en_d, mem_r_en_d, mem_w_en_d, b_d, s_d, is_mem_d;
  logic [CNT_W-1:0] bubble_count_d;
  logic [CNT_W-1:0] bubble_count_q;

  always_comb begin
    cap_en     = ~freeze;
    // An invalid decode slot must not cause any architectural side effect.
    wb_en_d    = id_wb_en & id_valid;
    mem_r_en_d = id_mem_r_en & id_valid;
    mem_w_en_d = id_mem_w_en & id_valid;
    b_d        = id_b & id_valid;
    s_d        = id_s & id_valid;
    is_mem_d   = (id_mem_r_en | id_mem_w_en) & id_valid;
    bubble     = flush | (~freeze & ~id_valid);
    bubble_count_d = bubble_count_q;
    if (bubble) begin
      bubble_count_d = sat_inc(bubble_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;

  pipe_reg #(.W(1)) u_valid (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_valid), .q(exe_valid));
  pipe_reg #(.W(1)) u_wb_en (.clk, .rst_n, .en(cap_en), .clr(flush), .d(wb_en_d), .q(exe_wb_en));
  pipe_reg #(.W(1)) u_mem_r (.clk, .rst_n, .en(cap_en), .clr(flush), .d(mem_r_en_d), .q(exe_mem_r_en));
  pipe_reg #(.W(1)) u_mem_w (.clk, .rst_n, .en(cap_en), .clr(flush), .d(mem_w_en_d), .q(exe_mem_w_en));
  pipe_reg #(.W(1)) u_b     (.clk, .rst_n, .en(cap_en), .clr(flush), .d(b_d), .q(exe_b));
  pipe_reg #(.W(1)) u_s     (.clk, .rst_n, .en(cap_en), .clr(flush), .d(s_d), .q(exe_s));
  pipe_reg #(.W(1)) u_is_mem (.clk, .rst_n, .en(cap_en), .clr(flush), .d(is_mem_d), .q(exe_is_mem_command));
  pipe_reg #(.W(EXE_CMD_W)) u_cmd (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_exe_cmd), .q(exe_exe_cmd));
  pipe_reg #(.W(DATA_W)) u_pc     (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_pc), .q(exe_pc));
  pipe_reg #(.W(DATA_W)) u_val_rn (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_val_rn), .q(exe_val_rn));
  pipe_reg #(.W(DATA_W)) u_val_rm (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_val_rm), .q(exe_val_rm));
  pipe_reg #(.W(1)) u_imm (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_imm), .q(exe_imm));
  pipe_reg #(.W(SHIFT_OP_W)) u_shop (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_shift_operand), .q(exe_shift_operand));
  pipe_reg #(.W(IMM24_W)) u_imm24 (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_signed_imm_24), .q(exe_signed_imm_24));
  pipe_reg #(.W(REG_IDX_W)) u_dest (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_dest), .q(exe_dest));
  pipe_reg #(.W(SR_W)) u_sr (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_sr), .q(exe_sr));

`ifdef FORWARDING_EN
  pipe_reg #(.W(REG_IDX_W)) u_src1 (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_src1), .q(exe_src1));
  pipe_reg #(.W(REG_IDX_W)) u_src2 (.clk, .rst_n, .en(cap_en), .clr(flush), .d(id_src2), .q(exe_src2));
`else
  // Source indices are only consumed by the forwarding unit.
  logic unused_src;
  assign unused_src = ^{id_src1, id_src2};
  assign exe_src1   = '0;
  assign exe_src2   = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: expected entries are predicted when the
// decode inputs are driven and compared one edge later.
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid, wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, sr, src1, src2;
    logic        is_mem;
  } ent_t;

  localparam int W = $bits(ent_t);

  logic clk = 1'b0;
  logic rst_n;
  logic freeze, flush;
  logic id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
  logic [3:0] id_exe_cmd;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic id_imm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic [3:0] id_dest, id_sr, id_src1, id_src2;
  logic exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s;
  logic [3:0] exe_exe_cmd;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic exe_imm;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [3:0] exe_dest, exe_sr, exe_src1, exe_src2;
  logic exe_is_mem_command;
  logic [31:0] bubble_count;

  id_exe_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_dest(id_dest), .id_sr(id_sr), .id_src1(id_src1), .id_src2(id_src2),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b), .exe_s(exe_s),
    .exe_exe_cmd(exe_exe_cmd), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn),
    .exe_val_rm(exe_val_rm), .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
    .exe_signed_imm_24(exe_signed_imm_24), .exe_dest(exe_dest), .exe_sr(exe_sr),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_is_mem_command(exe_is_mem_command),
    .bubble_count(bubble_count)
  );

  // Clock / reset infrastructure
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  ent_t act;
  assign act = '{exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s,
                 exe_exe_cmd, exe_pc, exe_val_rn, exe_val_rm, exe_imm,
                 exe_shift_operand, exe_signed_imm_24, exe_dest, exe_sr,
                 exe_src1, exe_src2, exe_is_mem_command};

  // Scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [31:0]   exp_bc_q[$];
  ent_t          m_ent;
  logic [31:0]   m_bc;
  int            total = 0;
  int            bad = 0;

  function automatic void count_bubble();
    if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
  endfunction

  // Reference behaviour of one edge, written from the register's contract.
  function automatic void predict();
    if (flush) begin
      m_ent = '0;
      count_bubble();
    end else if (!freeze) begin
      m_ent.valid         = id_valid;
      m_ent.wb_en         = id_valid ? id_wb_en : 1'b0;
      m_ent.mem_r_en      = id_valid ? id_mem_r_en : 1'b0;
      m_ent.mem_w_en      = id_valid ? id_mem_w_en : 1'b0;
      m_ent.b             = id_valid ? id_b : 1'b0;
      m_ent.s             = id_valid ? id_s : 1'b0;
      m_ent.exe_cmd       = id_exe_cmd;
      m_ent.pc            = id_pc;
      m_ent.val_rn        = id_val_rn;
      m_ent.val_rm        = id_val_rm;
      m_ent.imm           = id_imm;
      m_ent.shift_operand = id_shift_operand;
      m_ent.signed_imm_24 = id_signed_imm_24;
      m_ent.dest          = id_dest;
      m_ent.sr            = id_sr;
`ifdef FORWARDING_EN
      m_ent.src1          = id_src1;
      m_ent.src2          = id_src2;
`else
      m_ent.src1          = 4'h0;
      m_ent.src2          = 4'h0;
`endif
      m_ent.is_mem        = id_valid & (id_mem_r_en | id_mem_w_en);
      if (!id_valid) count_bubble();
    end
    exp_q.push_back(m_ent);
    exp_bc_q.push_back(m_bc);
  endfunction

  // Driver tasks
  task automatic rand_inputs();
    freeze = 1'b0; flush = 1'b0;
    id_valid = 1'($urandom_range(0, 1));
    id_wb_en = 1'($urandom_range(0, 1));
    id_mem_r_en = 1'($urandom_range(0, 1));
    id_mem_w_en = 1'($urandom_range(0, 1));
    id_b = 1'($urandom_range(0, 1));
    id_s = 1'($urandom_range(0, 1));
    id_exe_cmd = 4'($urandom_range(0, 15));
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_imm = 1'($urandom_range(0, 1));
    id_shift_operand = 12'($urandom_range(0, 4095));
    id_signed_imm_24 = 24'($urandom);
    id_dest = 4'($urandom_range(0, 15));
    id_sr = 4'($urandom_range(0, 15));
    id_src1 = 4'($urandom_range(0, 15));
    id_src2 = 4'($urandom_range(0, 15));
  endtask

  // Predict, advance one edge, then pop and compare.
  task automatic cycle(input string tag);
    ent_t e;
    logic [31:0] ebc;
    predict();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    ebc = exp_bc_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s entry: act=%h exp=%h", tag, act, e);
    end
    total++;
    if (bubble_count !== ebc) begin
      bad++;
      $display("FAIL %s bubble_count: act=%0d exp=%0d", tag, bubble_count, ebc);
    end
  endtask

  task automatic test_reset();
    rand_inputs();
    rst_n = 1'b0;
    m_ent = '0; m_bc = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (act !== ent_t'('0) || bubble_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: act=%h bc=%0d exp=0", act, bubble_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    rand_inputs();
    id_valid = 1'b1; id_val_rm = 32'h8000_0001; id_shift_operand = 12'h0E1; id_imm = 1'b0;
    cycle("capture");
    total++;
    if (exe_val_rm !== 32'h8000_0001 || exe_shift_operand !== 12'h0E1 || exe_valid !== 1'b1) begin
      bad++;
      $display("FAIL capture_fields: act=%h/%h/%b exp=80000001/0e1/1",
               exe_val_rm, exe_shift_operand, exe_valid);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] pcs[3];
    pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
    rand_inputs();
    id_valid = 1'b1; id_pc = 32'h0C;
    cycle("pre_freeze");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      freeze = 1'b1; id_pc = pcs[i];
      cycle("freeze");
      total++;
      if (exe_pc !== 32'h0C) begin
        bad++;
        $display("FAIL freeze_pc: act=%h exp=0000000c", exe_pc);
      end
    end
  endtask

  task automatic test_flush_freeze();
    logic [31:0] bc0;
    rand_inputs();
    id_valid = 1'b1; id_wb_en = 1'b1;
    cycle("pre_flush");
    bc0 = bubble_count;
    rand_inputs();
    flush = 1'b1; freeze = 1'b1; id_valid = 1'b1; id_wb_en = 1'b1;
    cycle("flush_freeze");
    total++;
    if (exe_valid !== 1'b0 || exe_wb_en !== 1'b0 || bubble_count !== bc0 + 32'd1) begin
      bad++;
      $display("FAIL flush_priority: act=%b/%b/%0d exp=0/0/%0d",
               exe_valid, exe_wb_en, bubble_count, bc0 + 32'd1);
    end
  endtask

  task automatic test_mem_cmd();
    rand_inputs();
    id_valid = 1'b1; id_mem_w_en = 1'b1;
    cycle("mem_valid");
    total++;
    if (exe_is_mem_command !== 1'b1) begin
      bad++;
      $display("FAIL mem_cmd_valid: act=%b exp=1", exe_is_mem_command);
    end
    id_valid = 1'b0;
    cycle("mem_invalid");
    total++;
    if (exe_is_mem_command !== 1'b0 || exe_mem_w_en !== 1'b0) begin
      bad++;
      $display("FAIL mem_cmd_invalid: act=%b/%b exp=0/0", exe_is_mem_command, exe_mem_w_en);
    end
  endtask

  task automatic test_forwarding();
    logic [3:0] exp_src1;
`ifdef FORWARDING_EN
    exp_src1 = 4'h5;
`else
    exp_src1 = 4'h0;
`endif
    rand_inputs();
    id_valid = 1'b1; id_src1 = 4'h5;
    cycle("forwarding");
    total++;
    if (exe_src1 !== exp_src1) begin
      bad++;
      $display("FAIL forwarding_src1: act=%h exp=%h", exe_src1, exp_src1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      cycle("random");
    end
  endtask

  task automatic test_async_reset();
    rand_inputs();
    id_valid = 1'b1; id_wb_en = 1'b1;
    cycle("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (act !== ent_t'('0) || bubble_count !== 32'd0 || clk !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: act=%h bc=%0d clk=%b exp=0/0/1", act, bubble_count, clk);
    end
    m_ent = '0; m_bc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_inputs();
    id_valid = 1'b1; id_wb_en = 1'b1;
    cycle("post_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      id_valid = 1'b1;
      cycle("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_freeze();
    test_flush_freeze();
    test_mem_cmd();
    test_forwarding();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
